instr_fetch_unit: RTL and testbench

- Consumer side of the 8-bit program-counter address stream.
- Accepts instruction addresses and issues single-outstanding read requests to instruction memory over a req/ack handshake.
- Buffers returned words with their addresses in a small FIFO and presents them to decode with valid/ready flow control.
- Sits between the PC counter and the decode stage; addr_ready is the stall the PC logic must honour.

---
 rtl/instr_fetch_unit_if.sv | 36 +++
 rtl/instr_fetch_unit.sv | 131 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// Fetch unit bus bundle: PC address stream, instruction memory port
// and decode-side valid/ready port.
interface instr_fetch_unit_if #(
   parameter int AW = 8,
   parameter int IW = 32
);
   logic [AW-1:0] addr_in;
   logic          addr_valid;
   logic          addr_ready;
   logic          flush;
   logic          mem_req;
   logic [AW-1:0] mem_addr;
   logic          mem_ack;
   logic [IW-1:0] mem_rdata;
   logic [IW-1:0] instr_out;
   logic [AW-1:0] instr_addr;
   logic          instr_valid;
   logic          instr_ready;
   logic [7:0]    fetch_cnt;

   modport master (
      output addr_in, addr_valid, flush,
      output mem_ack, mem_rdata, instr_ready,
      input  addr_ready, mem_req, mem_addr,
      input  instr_out, instr_addr, instr_valid,
      input  fetch_cnt
   );

   modport slave (
      input  addr_in, addr_valid, flush,
      input  mem_ack, mem_rdata, instr_ready,
      output addr_ready, mem_req, mem_addr,
      output instr_out, instr_addr, instr_valid,
      output fetch_cnt
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// Single-outstanding instruction fetcher with a small output FIFO
// between the PC stream and decode.
module instr_fetch_unit #(
   parameter int AW    = 8,
   parameter int IW    = 32,
   parameter int DEPTH = 2
) (
   input logic           clk,
   input logic           reset,
   instr_fetch_unit_if.slave bus
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int EW = AW + IW;

   typedef enum logic {IDLE, REQ} state_t;

   state_t        state;
   logic          req;
   logic [AW-1:0] maddr;
   logic          drop;
   logic [7:0]    fcnt;
   logic [IW-1:0] iout;
   logic [AW-1:0] iaddr;

   logic [EW-1:0] mem [DEPTH];
   logic [PW-1:0] rptr, wptr, rptr_n, wptr_n;
   logic [CW-1:0] count, count_n;

   logic          ack, ready, accept, push, pop;
   logic [EW-1:0] entry, head_n;

   function automatic logic [PW-1:0] inc(
      input logic [PW-1:0] p
   );
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign ack   = (state == REQ) && bus.mem_ack;
   assign ready = !bus.flush &&
                  ((state == IDLE && count < CW'(DEPTH)) ||
                   (ack && count < CW'(DEPTH - 1)));
   assign accept = bus.addr_valid && ready;
   assign push   = ack && !drop && !bus.flush;
   assign pop    = (count != '0) && bus.instr_ready;
   assign entry  = {maddr, bus.mem_rdata};

   always_comb begin
      rptr_n  = rptr;
      wptr_n  = wptr;
      count_n = count;
      if (bus.flush) begin
         rptr_n  = '0;
         wptr_n  = '0;
         count_n = '0;
      end else begin
         if (pop)  rptr_n = inc(rptr);
         if (push) wptr_n = inc(wptr);
         if (push && !pop) count_n = count + CW'(1);
         if (!push && pop) count_n = count - CW'(1);
      end
   end

   // A push into an empty (or just-drained) FIFO lands on the new head.
   always_comb begin
      head_n = mem[rptr_n];
      if (push && rptr_n == wptr) head_n = entry;
   end

   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= entry;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
         req   <= 1'b0;
         maddr <= '0;
         drop  <= 1'b0;
         fcnt  <= '0;
         rptr  <= '0;
         wptr  <= '0;
         count <= '0;
         iout  <= '0;
         iaddr <= '0;
      end else begin
         rptr  <= rptr_n;
         wptr  <= wptr_n;
         count <= count_n;
         if (push) fcnt <= fcnt + 8'd1;
         if (count_n != '0) {iaddr, iout} <= head_n;
         if (ack)
            drop <= 1'b0;
         else if (bus.flush && state == REQ)
            drop <= 1'b1;
         unique case (state)
            IDLE: begin
               if (accept) begin
                  state <= REQ;
                  req   <= 1'b1;
                  maddr <= bus.addr_in;
               end
            end
            REQ: begin
               if (ack) begin
                  if (accept) begin
                     maddr <= bus.addr_in;
                  end else begin
                     state <= IDLE;
                     req   <= 1'b0;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   a_no_overflow: assert property (
      @(posedge clk) disable iff (!reset)
      !(push && count == CW'(DEPTH))
   );

   assign bus.addr_ready  = ready;
   assign bus.mem_req     = req;
   assign bus.mem_addr    = maddr;
   assign bus.instr_out   = iout;
   assign bus.instr_addr  = iaddr;
   assign bus.instr_valid = (count != '0);
   assign bus.fetch_cnt   = fcnt;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: DEPTH=2 and DEPTH=4 instances against
// a transaction-level model, directed scenarios then random traffic.
module tb_instr_fetch_unit;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;
   logic [7:0] ain [2];
   logic       av [2];
   logic       fl, ir, ack;

   instr_fetch_unit_if bus2 ();
   instr_fetch_unit_if bus4 ();

   instr_fetch_unit #(.DEPTH(2)) u2 (
      .clk(clk), .reset(reset), .bus(bus2)
   );
   instr_fetch_unit #(.DEPTH(4)) u4 (
      .clk(clk), .reset(reset), .bus(bus4)
   );

   function automatic logic [31:0] mdata(input logic [7:0] a);
      if (a == 8'h05) return 32'hDEADBEEF;
      return {a ^ 8'hA5, 8'h3C, ~a, a};
   endfunction

   assign bus2.addr_in     = ain[0];
   assign bus2.addr_valid  = av[0];
   assign bus2.flush       = fl;
   assign bus2.instr_ready = ir;
   assign bus2.mem_ack     = ack;
   assign bus2.mem_rdata   = mdata(bus2.mem_addr);
   assign bus4.addr_in     = ain[1];
   assign bus4.addr_valid  = av[1];
   assign bus4.flush       = fl;
   assign bus4.instr_ready = ir;
   assign bus4.mem_ack     = ack;
   assign bus4.mem_rdata   = mdata(bus4.mem_addr);

   logic        rdy [2], req [2], iv [2];
   logic [7:0]  maddr [2], iaddr [2], fc [2];
   logic [31:0] iout [2];
   assign rdy[0] = bus2.addr_ready;  assign rdy[1] = bus4.addr_ready;
   assign req[0] = bus2.mem_req;     assign req[1] = bus4.mem_req;
   assign iv[0]  = bus2.instr_valid; assign iv[1]  = bus4.instr_valid;
   assign maddr[0] = bus2.mem_addr;  assign maddr[1] = bus4.mem_addr;
   assign iaddr[0] = bus2.instr_addr; assign iaddr[1] = bus4.instr_addr;
   assign iout[0]  = bus2.instr_out; assign iout[1]  = bus4.instr_out;
   assign fc[0]    = bus2.fetch_cnt; assign fc[1]    = bus4.fetch_cnt;

   // Model: pending request, drop flag and an in-order list of entries.
   int         depth [2];
   bit         pend [2];
   bit [7:0]   paddr [2];
   bit         drp [2];
   bit [39:0]  q [2][8];
   int         n [2];
   bit [39:0]  last [2];
   bit [7:0]   cnt [2];

   int tests = 0;
   int fails = 0;

   function automatic bit mrdy(int k);
      return !fl && ((!pend[k] && n[k] < depth[k]) ||
                     (pend[k] && ack && n[k] + 1 < depth[k]));
   endfunction

   task automatic model_update();
      for (int k = 0; k < 2; k++) begin
         bit acc, hit;
         acc = av[k] && mrdy(k);
         hit = pend[k] && ack;
         if (!reset) begin
            pend[k] = 0; paddr[k] = 0; drp[k] = 0;
            n[k] = 0; last[k] = 0; cnt[k] = 0;
         end else begin
            if (fl) begin
               n[k] = 0;
            end else begin
               if (n[k] > 0 && ir) begin
                  for (int i = 0; i < 7; i++) q[k][i] = q[k][i+1];
                  n[k]--;
               end
               if (hit && !drp[k]) begin
                  q[k][n[k]] = {paddr[k], mdata(paddr[k])};
                  n[k]++;
                  cnt[k]++;
               end
            end
            if (hit) drp[k] = 0;
            else if (fl && pend[k]) drp[k] = 1;
            if (acc) paddr[k] = ain[k];
            pend[k] = acc || (pend[k] && !ack);
            if (n[k] > 0) last[k] = q[k][0];
         end
      end
   endtask

   task automatic chk(string tag, logic [39:0] got, logic [39:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic check_all();
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("rdy%0d", k), 40'(rdy[k]), 40'(mrdy(k)));
         chk($sformatf("req%0d", k), 40'(req[k]), 40'(pend[k]));
         if (pend[k])
            chk($sformatf("maddr%0d", k), 40'(maddr[k]), 40'(paddr[k]));
         chk($sformatf("iv%0d", k), 40'(iv[k]), 40'(n[k] > 0));
         chk($sformatf("head%0d", k), {iaddr[k], iout[k]}, last[k]);
         chk($sformatf("fcnt%0d", k), 40'(fc[k]), 40'(cnt[k]));
      end
   endtask

   task automatic cyc();
      #1 check_all();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic drv(bit v, bit [7:0] a, bit f, bit r, bit k);
      av[0] = v; av[1] = v;
      ain[0] = a; ain[1] = a;
      fl = f; ir = r; ack = k;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      drv(0, 8'h00, 0, 0, 0);
      cyc();
      reset = 1'b1;
   endtask

   initial begin
      bit [7:0] nxt [2];
      bit       adv [2];
      bit [7:0] obs [$];
      int       nacc [2];
      bit       done;
      depth[0] = 2; depth[1] = 4;
      reset = 1'b0;
      drv(0, 8'h00, 0, 0, 0);
      @(posedge clk);
      model_update();
      @(negedge clk);
      cyc();
      reset = 1'b1;
      chk("rst_req", 40'(req[0]), 40'd0);
      chk("rst_iv", 40'(iv[1]), 40'd0);
      chk("rst_fc", 40'(fc[0]), 40'd0);

      // single fetch, ack on the third request cycle
      drv(1, 8'h05, 0, 0, 0);
      cyc();
      for (int i = 0; i < 3; i++) begin
         drv(0, 8'h00, 0, 0, i == 2);
         chk("sf_req", 40'(req[0]), 40'd1);
         chk("sf_addr", 40'(maddr[0]), 40'h05);
         cyc();
      end
      chk("sf_req_drop", 40'(req[0]), 40'd0);
      chk("sf_iv", 40'(iv[0]), 40'd1);
      chk("sf_head", {iaddr[0], iout[0]}, 40'h05DEADBEEF);
      chk("sf_fc", 40'(fc[0]), 40'd1);

      // back-pressure on the DEPTH=2 instance
      do_reset();
      drv(1, 8'h10, 0, 0, 1); cyc();
      drv(1, 8'h11, 0, 0, 1); cyc();
      for (int i = 0; i < 3; i++) begin
         drv(1, 8'h12, 0, 0, 1);
         #1 chk("bp_hold", 40'(rdy[0]), 40'd0);
         cyc();
      end
      chk("bp_head", 40'(iaddr[0]), 40'h10);
      drv(1, 8'h12, 0, 1, 1);
      #1 chk("bp_nocredit", 40'(rdy[0]), 40'd0);
      cyc();
      drv(1, 8'h12, 0, 0, 1);
      #1 chk("bp_accept", 40'(rdy[0]), 40'd1);
      chk("bp_pop", 40'(iaddr[0]), 40'h11);
      cyc();
      drv(0, 8'h00, 0, 0, 1); cyc();
      drv(0, 8'h00, 0, 1, 0);
      for (int i = 0; i < 4; i++) cyc();

      // back-to-back streaming
      do_reset();
      nxt[0] = 0; nxt[1] = 0;
      for (int c = 0; c < 16; c++) begin
         fl = 0; ir = 1; ack = 1;
         for (int k = 0; k < 2; k++) begin
            av[k] = nxt[k] < 8;
            ain[k] = nxt[k];
         end
         if (c < 8) #1 chk("b2b_rdy", 40'(rdy[1]), 40'd1);
         if (iv[1]) obs.push_back(iaddr[1]);
         for (int k = 0; k < 2; k++) adv[k] = av[k] && mrdy(k);
         cyc();
         for (int k = 0; k < 2; k++) if (adv[k]) nxt[k]++;
      end
      chk("b2b_len", 40'(obs.size()), 40'd8);
      for (int i = 0; i < obs.size(); i++)
         chk("b2b_order", 40'(obs[i]), 40'(i));
      chk("b2b_fc", 40'(fc[1]), 40'd8);

      // flush while a request is waiting
      do_reset();
      drv(1, 8'h20, 0, 1, 0); cyc();
      drv(0, 8'h00, 1, 1, 0);
      chk("fl_req0", 40'(req[0]), 40'd1);
      cyc();
      drv(0, 8'h00, 0, 1, 0);
      chk("fl_req1", 40'(req[0]), 40'd1);
      cyc();
      drv(0, 8'h00, 0, 1, 1);
      chk("fl_req2", 40'(req[0]), 40'd1);
      cyc();
      drv(0, 8'h00, 0, 1, 0);
      chk("fl_iv", 40'(iv[0]), 40'd0);
      chk("fl_fc", 40'(fc[0]), 40'd0);
      chk("fl_req_off", 40'(req[0]), 40'd0);
      cyc();
      drv(1, 8'h21, 0, 0, 0); cyc();
      drv(0, 8'h00, 0, 0, 1); cyc();
      chk("fl_next_iv", 40'(iv[0]), 40'd1);
      chk("fl_next_head", {iaddr[0], iout[0]},
          {8'h21, mdata(8'h21)});
      chk("fl_next_fc", 40'(fc[0]), 40'd1);

      // reset with one buffered entry and a request pending
      do_reset();
      drv(1, 8'h30, 0, 0, 0); cyc();
      drv(1, 8'h31, 0, 0, 1); cyc();
      chk("rm_pre_iv", 40'(iv[0]), 40'd1);
      chk("rm_pre_req", 40'(req[0]), 40'd1);
      reset = 1'b0;
      drv(0, 8'h00, 0, 0, 0); cyc();
      reset = 1'b1;
      chk("rm_req", 40'(req[0]), 40'd0);
      chk("rm_maddr", 40'(maddr[0]), 40'd0);
      chk("rm_iv", 40'(iv[0]), 40'd0);
      chk("rm_head", {iaddr[0], iout[0]}, 40'd0);
      chk("rm_fc", 40'(fc[0]), 40'd0);
      drv(0, 8'h00, 0, 0, 1); cyc();
      drv(0, 8'h00, 0, 0, 0);
      chk("rm_late_iv", 40'(iv[0]), 40'd0);
      chk("rm_late_fc", 40'(fc[0]), 40'd0);
      cyc();

      // random traffic against the model
      for (int c = 0; c < 600; c++) begin
         reset = ($urandom_range(0, 79) != 0);
         for (int k = 0; k < 2; k++) begin
            av[k]  = $urandom_range(0, 2) != 0;
            ain[k] = 8'($urandom);
         end
         fl  = $urandom_range(0, 15) == 0;
         ir  = $urandom_range(0, 1) == 1;
         ack = $urandom_range(0, 1) == 1;
         cyc();
      end
      reset = 1'b1;

      // 256 completed fetches wrap the counter
      do_reset();
      nacc[0] = 0; nacc[1] = 0;
      done = 0;
      for (int c = 0; c < 2000 && !done; c++) begin
         fl = 0; ir = 1; ack = 1;
         for (int k = 0; k < 2; k++) begin
            av[k]  = nacc[k] < 256;
            ain[k] = 8'($urandom);
            if (av[k] && mrdy(k)) nacc[k]++;
         end
         cyc();
         done = nacc[0] == 256 && nacc[1] == 256 &&
                !pend[0] && !pend[1] && n[0] == 0 && n[1] == 0;
      end
      chk("wrap_done", 40'(done), 40'd1);
      chk("wrap_fc2", 40'(fc[0]), 40'h00);
      chk("wrap_fc4", 40'(fc[1]), 40'h00);
      drv(0, 8'h00, 0, 1, 0);
      cyc();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
